multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32I execute datapath (register file, ALU-source mux, ALU) and a shared single-port instruction/data memory.
- Drives WE3, ALUSrc, ALUctrl, PC and IR enables, and memory request handshake. One instruction in flight.
- Sits beside top_execute; consumes the IR contents and the ALU EQ flag.

Parameters:
DATA_WIDTH, 32, instruction/IR width
ALUCTRL_WIDTH, 3, ALU operation select width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
instr  input  DATA_WIDTH  IR contents; valid from DECODE onward
EQ  input  1  ALU zero/equal flag
mem_ready  input  1  memory access complete this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write (store)
mem_addr_src  output  1  0=PC, 1=ALUout
ir_we  output  1  load IR
pc_we  output  1  update PC
pc_src  output  1  0=PC+4, 1=PC+ImmExt
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUSrc  output  1  0=RD2, 1=ImmExt
ALUctrl  output  ALUCTRL_WIDTH  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
WE3  output  1  register write enable
result_src  output  2  00 ALUout, 01 mem rdata, 10 PC+4, 11 ImmExt
instr_done  output  1  one-cycle pulse at instruction retirement
trap  output  1  illegal-instruction halt flag

Behaviour:
- Reset (async, any state): state=FETCH; all outputs 0 immediately; in-flight mem_req dropped; no handshake completes.
- FETCH: mem_req=1, mem_addr_src=0, mem_we=0. Hold until mem_ready. On mem_ready: ir_we=1 same cycle, go DECODE.
- DECODE (1 cycle): classify opcode. 0110011 R, 0010011 I-ALU, 0000011 lw, 0100011 sw -> EXEC. 1100011 beq/bne -> BRANCH. 1101111 jal -> JAL. 0110111 lui -> LUI. Anything else -> ILLEGAL.
- ALU decode (R/I), by funct3: 000 ADD (SUB if R and funct7[5]=1), 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL. funct3=011 -> ILLEGAL. lw/sw use ADD with ALUSrc=1.
- EXEC: ALUSrc=1 for I/lw/sw, 0 for R. R/I -> WB. lw/sw -> MEM.
- MEM: mem_req=1, mem_addr_src=1, mem_we=1 for sw. Hold ALUSrc and ALUctrl stable while waiting.
  - On mem_ready, lw -> WB with result_src=01.
  - On mem_ready, sw retires: pc_we=1, pc_src=0, instr_done=1, go FETCH.
- WB: WE3=1, pc_we=1, pc_src=0, instr_done=1, go FETCH.
- BRANCH: ALUSrc=0, ALUctrl=SUB, ImmSrc=010. taken = EQ XOR funct3[0]; funct3 other than 000/001 -> ILLEGAL. pc_we=1, pc_src=taken, instr_done=1, go FETCH.
- JAL: ImmSrc=011, WE3=1, result_src=10, pc_we=1, pc_src=1, instr_done=1, go FETCH.
- LUI: ImmSrc=100, WE3=1, result_src=11, pc_we=1, pc_src=0, instr_done=1, go FETCH.
- WE3 is suppressed (forced 0) whenever rd (instr[11:7]) = 0.
- mem_ready is ignored outside FETCH/MEM. mem_req stays high continuously across wait cycles. WE3, pc_we and instr_done are each exactly one cycle per instruction.
- Latency with zero-wait memory:
  - R/I, sw: 4 cycles
  - lw: 5 cycles
  - branch, jal, lui: 3 cycles
  - each memory wait cycle adds 1.
- ILLEGAL: see Optional Feature.

Optional Feature:
- MC_ILLEGAL_TRAP_EN defined: ILLEGAL enters HALT. trap=1, all other outputs 0, PC not advanced. Only rst exits.
- Undefined: ILLEGAL behaves as NOP. pc_we=1, pc_src=0, instr_done=1, go FETCH. trap is tied 0.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready always 1 -> ir_we at cycle 0, WE3=1 with ALUctrl=000 ALUSrc=0 on cycle 3; instr_done on cycle 3.
- sub x3,x1,x2 then sw x2,4(x1) with 2 mem wait cycles in MEM -> ALUctrl=001; sw asserts mem_req+mem_we for 3 cycles, retires on mem_ready, WE3 never 1.
- beq x1,x2,+8 with EQ=1, then bne with EQ=1 -> first pc_src=1, second pc_src=0; both 3-cycle retire.
- addi x0,x1,5 -> WE3 stays 0, pc_we=1, instr_done=1.
- Opcode 0x7F: with MC_ILLEGAL_TRAP_EN -> trap=1 and stuck. Without it -> NOP, PC+4, instr_done=1.
- Assert rst while in MEM with mem_req=1 -> mem_req=0 same cycle, state FETCH after release, next fetch completes normally.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control bundle between the multi-cycle RV32I controller and
//                the execute datapath / shared instruction-data memory.
//                master : controller side (drives the control signals)
//                slave  : datapath / memory side (drives instr, EQ, mem_ready)
//  Signals     : instr, EQ, mem_ready              -> controller
//                mem_req, mem_we, mem_addr_src, ir_we, pc_we, pc_src, ImmSrc,
//                ALUSrc, ALUctrl, WE3, result_src, instr_done, trap
//                                                  -> datapath / memory
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]    instr;
  logic                     EQ;
  logic                     mem_ready;
  logic                     mem_req;
  logic                     mem_we;
  logic                     mem_addr_src;
  logic                     ir_we;
  logic                     pc_we;
  logic                     pc_src;
  logic [2:0]               ImmSrc;
  logic                     ALUSrc;
  logic [ALUCTRL_WIDTH-1:0] ALUctrl;
  logic                     WE3;
  logic [1:0]               result_src;
  logic                     instr_done;
  logic                     trap;

  modport master (
    input  instr, EQ, mem_ready,
    output mem_req, mem_we, mem_addr_src, ir_we, pc_we, pc_src, ImmSrc,
           ALUSrc, ALUctrl, WE3, result_src, instr_done, trap
  );

  modport slave (
    output instr, EQ, mem_ready,
    input  mem_req, mem_we, mem_addr_src, ir_we, pc_we, pc_src, ImmSrc,
           ALUSrc, ALUctrl, WE3, result_src, instr_done, trap
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM for the RV32I execute datapath and a
//                shared single-port instruction/data memory. One instruction
//                in flight: FETCH -> DECODE -> (EXEC -> MEM/WB | BRANCH | JAL
//                | LUI | ILLEGAL) -> FETCH.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - multicycle_ctrl_if.master control bundle
//  Options     : MC_ILLEGAL_TRAP_EN - defined: illegal instruction halts with
//                trap=1 until reset. Undefined: illegal instruction retires
//                as a NOP and trap is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(0);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(1);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(2);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR = ALUCTRL_WIDTH'(4);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(5);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL = ALUCTRL_WIDTH'(6);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL = ALUCTRL_WIDTH'(7);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_MEM     = 4'd3,
    S_WB      = 4'd4,
    S_BRANCH  = 4'd5,
    S_JAL     = 4'd6,
    S_LUI     = 4'd7,
    S_ILLEGAL = 4'd8,
    S_HALT    = 4'd9
  } state_t;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t ILL_TARGET = S_HALT;
`else
  localparam state_t ILL_TARGET = S_ILLEGAL;
`endif

  state_t                   state_q;
  logic                     alu_src_q;
  logic [ALUCTRL_WIDTH-1:0] alu_ctrl_q;
  logic [2:0]               imm_src_q;
  logic [1:0]               result_src_q;
  logic                     we3_q;
  logic                     pc_we_q;
  logic                     pc_src_q;
  logic                     done_q;
  logic                     load_q;
  logic                     store_q;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                     trap_q;
`endif

  logic [6:0]               w_opcode;
  logic [2:0]               w_funct3;
  logic                     w_rd_nz;
  logic                     w_is_ls;
  logic [ALUCTRL_WIDTH-1:0] w_alu_op;
  state_t                   w_dec_state;
  logic                     w_st_retire;
  logic                     w_unused_bits;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_rd_nz  = |bus.instr[11:7];
  assign w_is_ls  = (w_opcode == OP_LW) || (w_opcode == OP_SW);
  assign w_unused_bits = ^{bus.instr[DATA_WIDTH-1], bus.instr[29:15]};

  // R/I ALU operation; funct7[5] only selects SUB for register-register adds
  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_op = ((w_opcode == OP_R) && bus.instr[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_op = ALU_AND;
      3'b110:  w_alu_op = ALU_OR;
      3'b100:  w_alu_op = ALU_XOR;
      3'b010:  w_alu_op = ALU_SLT;
      3'b001:  w_alu_op = ALU_SLL;
      3'b101:  w_alu_op = ALU_SRL;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  // Opcode classification, including the funct3 encodings we do not support
  always_comb begin
    w_dec_state = S_ILLEGAL;
    case (w_opcode)
      OP_R, OP_I:   w_dec_state = (w_funct3 == 3'b011) ? S_ILLEGAL : S_EXEC;
      OP_LW, OP_SW: w_dec_state = S_EXEC;
      OP_BR:        w_dec_state = (w_funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
      OP_JAL:       w_dec_state = S_JAL;
      OP_LUI:       w_dec_state = S_LUI;
      default:      w_dec_state = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      imm_src_q    <= '0;
      result_src_q <= '0;
      we3_q        <= 1'b0;
      pc_we_q      <= 1'b0;
      pc_src_q     <= 1'b0;
      done_q       <= 1'b0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      // Retirement strobes live for exactly one cycle
      we3_q    <= 1'b0;
      pc_we_q  <= 1'b0;
      pc_src_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          state_q <= (w_dec_state == S_ILLEGAL) ? ILL_TARGET : w_dec_state;
          load_q  <= (w_opcode == OP_LW);
          store_q <= (w_opcode == OP_SW);
          case (w_dec_state)
            S_EXEC: begin
              alu_src_q  <= (w_opcode != OP_R);
              alu_ctrl_q <= w_is_ls ? ALU_ADD : w_alu_op;
              imm_src_q  <= (w_opcode == OP_SW) ? IMM_S : IMM_I;
            end
            S_BRANCH: begin
              alu_src_q  <= 1'b0;
              alu_ctrl_q <= ALU_SUB;
              imm_src_q  <= IMM_B;
              pc_we_q    <= 1'b1;
              done_q     <= 1'b1;
            end
            S_JAL: begin
              imm_src_q    <= IMM_J;
              result_src_q <= RES_PC4;
              we3_q        <= w_rd_nz;
              pc_we_q      <= 1'b1;
              pc_src_q     <= 1'b1;
              done_q       <= 1'b1;
            end
            S_LUI: begin
              imm_src_q    <= IMM_U;
              result_src_q <= RES_IMM;
              we3_q        <= w_rd_nz;
              pc_we_q      <= 1'b1;
              done_q       <= 1'b1;
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
              trap_q  <= 1'b1;
`else
              pc_we_q <= 1'b1;
              done_q  <= 1'b1;
`endif
            end
          endcase
        end
        S_EXEC: begin
          if (load_q || store_q) begin
            state_q <= S_MEM;
          end else begin
            state_q      <= S_WB;
            result_src_q <= RES_ALU;
            we3_q        <= w_rd_nz;
            pc_we_q      <= 1'b1;
            done_q       <= 1'b1;
          end
        end
        S_MEM: begin
          // ALU controls stay untouched here so the address holds during waits
          if (bus.mem_ready) begin
            if (store_q) begin
              state_q      <= S_FETCH;
              alu_src_q    <= 1'b0;
              alu_ctrl_q   <= '0;
              imm_src_q    <= '0;
              result_src_q <= '0;
            end else begin
              state_q      <= S_WB;
              result_src_q <= RES_MEM;
              we3_q        <= w_rd_nz;
              pc_we_q      <= 1'b1;
              done_q       <= 1'b1;
            end
          end
        end
        S_WB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL: begin
          state_q      <= S_FETCH;
          alu_src_q    <= 1'b0;
          alu_ctrl_q   <= '0;
          imm_src_q    <= '0;
          result_src_q <= '0;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Memory-facing strobes follow the state register; the reset term keeps the
  // bus quiet while rst is held even though the state already reads FETCH.
  assign w_st_retire = (state_q == S_MEM) && store_q && bus.mem_ready;

  assign bus.mem_req      = !rst && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign bus.mem_we       = (state_q == S_MEM) && store_q;
  assign bus.mem_addr_src = (state_q == S_MEM);
  assign bus.ir_we        = !rst && (state_q == S_FETCH) && bus.mem_ready;
  assign bus.pc_we        = pc_we_q | w_st_retire;
  assign bus.instr_done   = done_q | w_st_retire;
  // Branch direction depends on this cycle's EQ, so it cannot be registered
  assign bus.pc_src       = pc_src_q |
                            ((state_q == S_BRANCH) && (bus.EQ ^ w_funct3[0]));
  assign bus.ImmSrc       = imm_src_q;
  assign bus.ALUSrc       = alu_src_q;
  assign bus.ALUctrl      = alu_ctrl_q;
  assign bus.WE3          = we3_q;
  assign bus.result_src   = result_src_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.trap         = trap_q;
`else
  assign bus.trap         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed bench for multicycle_ctrl. Each cycle the control
//                outputs are packed as
//                {mem_req, mem_we, mem_addr_src, ir_we, pc_we, pc_src,
//                 ImmSrc[2:0], ALUSrc, ALUctrl[2:0], WE3, result_src[1:0],
//                 instr_done, trap}
//                and compared against hand-derived vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] V_ZERO  = 18'b0000_00_000_0_000_0_00_0_0;
  localparam logic [17:0] V_FETCH = 18'b1001_00_000_0_000_0_00_0_0;
  localparam logic [17:0] V_FWAIT = 18'b1000_00_000_0_000_0_00_0_0;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic [17:0] V_ILL   = 18'b0000_00_000_0_000_0_00_0_1;
`else
  localparam logic [17:0] V_ILL   = 18'b0000_10_000_0_000_0_00_1_0;
`endif

  function automatic logic [17:0] obs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_src, bus.ir_we, bus.pc_we,
            bus.pc_src, bus.ImmSrc, bus.ALUSrc, bus.ALUctrl, bus.WE3,
            bus.result_src, bus.instr_done, bus.trap};
  endfunction

  // Apply this cycle's inputs, then move to the sampling point (negedge)
  task automatic step(input logic rdy, input logic eq);
    bus.mem_ready = rdy;
    bus.EQ        = eq;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== V_ZERO) begin
        failed++;
        $display("FAIL reset cycle %0d: got %b, expected %b", i, obs(), V_ZERO);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [17:0] want [4];
    want[0] = V_FETCH;
    want[1] = V_ZERO;
    want[2] = V_ZERO;
    want[3] = 18'b0000_10_000_0_000_1_00_1_0;
    bus.instr = 32'h002081B3;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL add cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] want [11];
    logic        rdy  [11];
    // sub x3,x1,x2
    want[0]  = V_FETCH;                       rdy[0]  = 1'b1;
    want[1]  = V_ZERO;                        rdy[1]  = 1'b1;
    want[2]  = 18'b0000_00_000_0_001_0_00_0_0; rdy[2]  = 1'b1;
    want[3]  = 18'b0000_10_000_0_001_1_00_1_0; rdy[3]  = 1'b1;
    // sw x2,4(x1) with two memory wait cycles
    want[4]  = V_FETCH;                       rdy[4]  = 1'b1;
    want[5]  = V_ZERO;                        rdy[5]  = 1'b0;
    want[6]  = 18'b0000_00_001_1_000_0_00_0_0; rdy[6]  = 1'b0;
    want[7]  = 18'b1110_00_001_1_000_0_00_0_0; rdy[7]  = 1'b0;
    want[8]  = 18'b1110_00_001_1_000_0_00_0_0; rdy[8]  = 1'b0;
    want[9]  = 18'b1110_10_001_1_000_0_00_1_0; rdy[9]  = 1'b1;
    want[10] = V_FWAIT;                       rdy[10] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.instr = (i < 4) ? 32'h402081B3 : 32'h0020A223;
      step(rdy[i], 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL sub_sw cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
  endtask

  task automatic test_load();
    logic [17:0] want [5];
    want[0] = V_FETCH;
    want[1] = V_ZERO;
    want[2] = 18'b0000_00_000_1_000_0_00_0_0;
    want[3] = 18'b1010_00_000_1_000_0_00_0_0;
    want[4] = 18'b0000_10_000_1_000_1_01_1_0;
    bus.instr = 32'h0080A283;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL lw cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins  [3];
    logic        eqv  [3];
    logic [17:0] last [3];
    logic [17:0] want;
    ins[0] = 32'h00208463; eqv[0] = 1'b1; last[0] = 18'b0000_11_010_0_001_0_00_1_0;
    ins[1] = 32'h00209463; eqv[1] = 1'b1; last[1] = 18'b0000_10_010_0_001_0_00_1_0;
    ins[2] = 32'h00208463; eqv[2] = 1'b0; last[2] = 18'b0000_10_010_0_001_0_00_1_0;
    for (int k = 0; k < 3; k++) begin
      bus.instr = ins[k];
      for (int i = 0; i < 3; i++) begin
        want = (i == 0) ? V_FETCH : (i == 1) ? V_ZERO : last[k];
        step(1'b1, eqv[k]);
        tests++;
        if (obs() !== want) begin
          failed++;
          $display("FAIL branch%0d cycle %0d: got %b, expected %b", k, i, obs(), want);
        end
        adv();
      end
    end
  endtask

  task automatic test_rd_zero();
    logic [17:0] want [4];
    want[0] = V_FETCH;
    want[1] = V_ZERO;
    want[2] = 18'b0000_00_000_1_000_0_00_0_0;
    want[3] = 18'b0000_10_000_1_000_0_00_1_0;
    bus.instr = 32'h00508013;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL addi_x0 cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
  endtask

  task automatic test_jal_lui();
    logic [31:0] ins  [2];
    logic [17:0] last [2];
    logic [17:0] want;
    ins[0] = 32'h010000EF; last[0] = 18'b0000_11_011_0_000_1_10_1_0;
    ins[1] = 32'h123452B7; last[1] = 18'b0000_10_100_0_000_1_11_1_0;
    for (int k = 0; k < 2; k++) begin
      bus.instr = ins[k];
      for (int i = 0; i < 3; i++) begin
        want = (i == 0) ? V_FETCH : (i == 1) ? V_ZERO : last[k];
        step(1'b1, 1'b0);
        tests++;
        if (obs() !== want) begin
          failed++;
          $display("FAIL jal_lui%0d cycle %0d: got %b, expected %b", k, i, obs(), want);
        end
        adv();
      end
    end
  endtask

  task automatic test_illegal();
    logic [17:0] want [5];
    want[0] = V_FETCH;
    want[1] = V_ZERO;
    want[2] = V_ILL;
`ifdef MC_ILLEGAL_TRAP_EN
    want[3] = V_ILL;
    want[4] = V_ILL;
`else
    want[3] = V_FETCH;
    want[4] = V_ZERO;
`endif
    bus.instr = 32'h0000007F;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL illegal_op cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
    do_reset();
    // R-type with the unsupported funct3=011
    bus.instr = 32'h0020B1B3;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL illegal_f3 cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
    do_reset();
  endtask

  task automatic test_reset_in_mem();
    logic [17:0] want [4];
    bus.instr = 32'h0080A283;
    step(1'b1, 1'b0); adv();
    step(1'b0, 1'b0); adv();
    step(1'b0, 1'b0); adv();
    step(1'b0, 1'b0);
    tests++;
    if (obs() !== 18'b1010_00_000_1_000_0_00_0_0) begin
      failed++;
      $display("FAIL rst_mem wait: got %b, expected %b", obs(), 18'b1010_00_000_1_000_0_00_0_0);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (obs() !== V_ZERO) begin
      failed++;
      $display("FAIL rst_mem async: got %b, expected %b", obs(), V_ZERO);
    end
    adv();
    rst = 1'b0;
    want[0] = V_FETCH;
    want[1] = V_ZERO;
    want[2] = V_ZERO;
    want[3] = 18'b0000_10_000_0_000_1_00_1_0;
    bus.instr = 32'h002081B3;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs() !== want[i]) begin
        failed++;
        $display("FAIL rst_mem refetch cycle %0d: got %b, expected %b", i, obs(), want[i]);
      end
      adv();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.instr     = '0;
    bus.EQ        = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_load();
    test_branch();
    test_rd_zero();
    test_jal_lui();
    test_illegal();
    test_reset_in_mem();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
